// File: rtl/l4_pkg.sv
// Shared definitions for the layer-4 fully-connected stage.
//   state_t      FSM states of layer_4_fc
//   feat_word_t  one pooled feature word: 4 channels x DW signed bits
//   sat_dw()     saturate a shifted accumulator value to DW signed bits
package l4_pkg;

  localparam int N_WORDS = 16;   // feature words per image
  localparam int N_OUT   = 10;   // output neurons
  localparam int N_CH    = 4;    // channels per word (MACs per cycle)
  localparam int DW      = 18;   // feature / weight / bias / score width
  localparam int ACC_W   = 40;   // accumulator width
  localparam int SHIFT   = 8;    // accumulator fraction bits dropped before saturation

  localparam int WA_W    = $clog2(N_WORDS);
  localparam int NA_W    = $clog2(N_OUT);
  localparam int ROM_AW  = NA_W + WA_W;
  localparam int ROM_DW  = (N_CH + 1) * DW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DW-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DW-1)));

  typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, DONE} state_t;

  typedef logic [N_CH-1:0][DW-1:0] feat_word_t;

  function automatic logic [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
    else                  return v[DW-1:0];
  endfunction

endpackage

// File: rtl/l4_weight_rom.sv
// Synchronous weight/bias ROM for layer_4_fc (1-cycle read latency).
//   clk     clock
//   addr    {neuron, word}
//   weight  4 signed DW-bit weights for that neuron/word, channel c at weight[c]
//   bias    signed DW-bit bias field of the same entry
// Entry layout: {bias, w3, w2, w1, w0}. The FC stage samples the bias from the
// entry of the last word of each neuron; other entries' bias fields are unused.
module l4_weight_rom
  import l4_pkg::*;
#(
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [ROM_AW-1:0]        addr,
  output logic [N_CH-1:0][DW-1:0]  weight,
  output logic [DW-1:0]            bias
);

  logic [ROM_DW-1:0] mem [2**ROM_AW];
  logic [ROM_DW-1:0] q;

  always_ff @(posedge clk) begin
    q <= mem[addr];
  end

  assign weight = q[N_CH*DW-1:0];
  assign bias   = q[ROM_DW-1 -: DW];

endmodule

// File: rtl/layer_4_fc.sv
// Fully-connected output stage behind the layer-3 pooled-feature buffer.
// Loads N_WORDS x 4 features, computes N_OUT saturated scores with 4 MACs per
// cycle (ROM stage + multiply-add stage), streams them, then pulses tx_done.
//   clk, rst      clock, synchronous active-high reset
//   rd, din       upstream word available / show-ahead features
//   addr_rd_inc   consume current din word (LOAD only)
//   tx_done       1-cycle pulse after the last score
//   busy          FSM not IDLE
//   score, score_vld, score_idx   streamed neuron scores
//   class_idx, class_vld          argmax result (only with ARGMAX_EN defined)
// Optional feature macro: ARGMAX_EN.
module layer_4_fc
  import l4_pkg::*;
#(
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd,
  input  logic [N_CH-1:0][DW-1:0]  din,
  output logic                     addr_rd_inc,
  output logic                     tx_done,
  output logic                     busy,
  output logic [DW-1:0]            score,
  output logic                     score_vld,
  output logic [NA_W-1:0]          score_idx,
  output logic [NA_W-1:0]          class_idx,
  output logic                     class_vld
);

  state_t                   state;
  feat_word_t               fbuf [N_WORDS];
  logic [WA_W-1:0]          wcnt;
  logic [WA_W:0]            mcnt;
  logic [NA_W-1:0]          ncnt;
  logic                     acc_en;
  logic signed [ACC_W-1:0]  acc;
  feat_word_t               feat_q;
  feat_word_t               rom_w;
  logic [DW-1:0]            rom_b;
  logic [WA_W-1:0]          rd_w;
  logic [ROM_AW-1:0]        rom_addr;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  acc_biased;
  logic signed [DW-1:0]     score_new;

  // Word index clamps at the last word on the drain cycle so the ROM output
  // seen in BIAS is the last word's entry, which carries the bias.
  assign rd_w     = (mcnt >= (WA_W+1)'(N_WORDS)) ? WA_W'(N_WORDS-1) : mcnt[WA_W-1:0];
  assign rom_addr = {ncnt, rd_w};

  // Show-ahead handshake: the consume strobe must be combinational, otherwise
  // back-to-back words would be read twice.
  assign addr_rd_inc = (state == LOAD) && rd && !rst;
  assign busy        = (state != IDLE);

  l4_weight_rom #(.INIT_FILE(INIT_FILE)) u_rom (
    .clk    (clk),
    .addr   (rom_addr),
    .weight (rom_w),
    .bias   (rom_b)
  );

  always_comb begin
    mac_sum = '0;
    prod    = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      prod    = $signed(feat_q[c]) * $signed(rom_w[c]);
      mac_sum = mac_sum + ACC_W'(prod);
    end
  end

  assign acc_biased = acc + (ACC_W'($signed(rom_b)) <<< SHIFT);
  assign score_new  = sat_dw(acc_biased >>> SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      mcnt      <= '0;
      ncnt      <= '0;
      acc_en    <= 1'b0;
      acc       <= '0;
      feat_q    <= '0;
      tx_done   <= 1'b0;
      score     <= '0;
      score_vld <= 1'b0;
      score_idx <= '0;
    end else begin
      tx_done   <= 1'b0;
      score_vld <= 1'b0;
      // Stage 1 (ROM read + feature fetch) valid flag for stage 2.
      acc_en    <= (state == MAC) && (mcnt < (WA_W+1)'(N_WORDS));
      feat_q    <= fbuf[rd_w];
      if (acc_en) acc <= acc + mac_sum;

      case (state)
        IDLE: begin
          if (rd) begin
            state <= LOAD;
            wcnt  <= '0;
          end
        end
        LOAD: begin
          if (rd) begin
            fbuf[wcnt] <= din;
            wcnt       <= wcnt + 1'b1;
            if (wcnt == WA_W'(N_WORDS-1)) begin
              state <= MAC;
              mcnt  <= '0;
              ncnt  <= '0;
            end
          end
        end
        MAC: begin
          // N_WORDS issue cycles plus one drain cycle for the multiply-add stage.
          if (mcnt == (WA_W+1)'(N_WORDS)) state <= BIAS;
          else                            mcnt  <= mcnt + 1'b1;
        end
        BIAS: begin
          score     <= score_new;
          score_vld <= 1'b1;
          score_idx <= ncnt;
          acc       <= '0;
          mcnt      <= '0;
          if (ncnt == NA_W'(N_OUT-1)) begin
            state <= DONE;
          end else begin
            ncnt  <= ncnt + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          tx_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARGMAX_EN
  logic signed [DW-1:0] max_score;
  logic [NA_W-1:0]      max_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_score <= '0;
      max_idx   <= '0;
      class_idx <= '0;
      class_vld <= 1'b0;
    end else begin
      class_vld <= 1'b0;
      // Neuron 0 seeds the running max; strict > keeps the lower index on ties.
      if (state == BIAS && (ncnt == '0 || score_new > max_score)) begin
        max_score <= score_new;
        max_idx   <= ncnt;
      end
      if (state == DONE) begin
        class_vld <= 1'b1;
        class_idx <= max_idx;
      end
    end
  end
`else
  assign class_idx = '0;
  assign class_vld = 1'b0;
`endif

endmodule

// File: tb/tb_layer_4_fc.sv
// Self-checking bench for layer_4_fc: randomized images and ROM contents,
// a behavioural score model, and a per-cycle compare process.
module tb_layer_4_fc;
  import l4_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rd  = 1'b0;
  logic [N_CH-1:0][DW-1:0] din = '0;
  logic                    addr_rd_inc, tx_done, busy, score_vld, class_vld;
  logic [DW-1:0]           score;
  logic [NA_W-1:0]         score_idx, class_idx;

  always #5 clk = ~clk;

  layer_4_fc dut (
    .clk(clk), .rst(rst), .rd(rd), .din(din),
    .addr_rd_inc(addr_rd_inc), .tx_done(tx_done), .busy(busy),
    .score(score), .score_vld(score_vld), .score_idx(score_idx),
    .class_idx(class_idx), .class_vld(class_vld)
  );

  localparam int FIRST = N_WORDS + 3;   // cycles from last consumed word to first score
  localparam int GAP   = N_WORDS + 2;   // cycles between scores
  localparam int TXOFF = FIRST + GAP*(N_OUT-1) + 1;
  localparam longint SMAX = 2**(DW-1) - 1;
  localparam longint SMIN = -(2**(DW-1));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference data: what the ROM holds, what the stimulus offers, what was consumed.
  int wm  [N_OUT][N_WORDS][N_CH];
  int bm  [N_OUT];
  int img [N_WORDS][N_CH];
  int fm  [N_WORDS][N_CH];
  logic [DW-1:0] exp_sc [N_OUT];
  logic [DW-1:0] got_sc [N_OUT];
  int got_cnt = 0;
  int exp_cls = 0;
  int got_cls = 0;

  function automatic logic [DW-1:0] model_score(int n);
    longint acc = 0;
    for (int w = 0; w < N_WORDS; w++)
      for (int c = 0; c < N_CH; c++)
        acc += longint'(fm[w][c]) * longint'(wm[n][w][c]);
    acc += longint'(bm[n]) * (2**SHIFT);
    acc = (acc <<< (64-ACC_W)) >>> (64-ACC_W);   // accumulator wraps at ACC_W bits
    acc = acc >>> SHIFT;
    if (acc > SMAX) return DW'(SMAX);
    if (acc < SMIN) return DW'(SMIN);
    return DW'(acc);
  endfunction

  task automatic rom_flush();
    logic [ROM_DW-1:0] word;
    for (int n = 0; n < N_OUT; n++)
      for (int w = 0; w < N_WORDS; w++) begin
        for (int c = 0; c < N_CH; c++) word[c*DW +: DW] = DW'(wm[n][w][c]);
        word[N_CH*DW +: DW] = DW'(bm[n]);
        dut.u_rom.mem[n*N_WORDS + w] = word;
      end
  endtask

  function automatic int rnd(int r);
    return int'($urandom_range(0, 2*r)) - r;
  endfunction

  // Compare process: sampled on the falling edge.
  int cyc = 0, pending = 0, wcount = 0, nexp = 0, base = 0;
  always @(negedge clk) begin
    logic ev, et;
    cyc++;
    if (rst) begin
      pending = 0;
      wcount  = 0;
    end else begin
      chk("inc_gate", addr_rd_inc && (pending != 0 || !rd), 0);
      if (addr_rd_inc && pending == 0) begin
        for (int c = 0; c < N_CH; c++) fm[wcount][c] = int'($signed(din[c]));
        wcount++;
        if (wcount == N_WORDS) begin
          for (int n = 0; n < N_OUT; n++) exp_sc[n] = model_score(n);
          exp_cls = 0;
          for (int n = 1; n < N_OUT; n++)
            if ($signed(exp_sc[n]) > $signed(exp_sc[exp_cls])) exp_cls = n;
          pending = 1; base = cyc; nexp = 0; got_cnt = 0; wcount = 0;
        end
      end
      ev = (pending != 0) && (nexp < N_OUT) && (cyc == base + FIRST + GAP*nexp);
      chk("score_vld", score_vld, ev);
      if (ev && score_vld) begin
        chk("score_idx", score_idx, nexp);
        chk("score", score, exp_sc[nexp]);
        got_sc[nexp] = score;
        got_cnt++;
      end
      if (ev) nexp++;
      et = (pending != 0) && (cyc == base + TXOFF);
      chk("tx_done", tx_done, et);
      if (pending != 0) chk("busy", busy, cyc < base + TXOFF);
`ifdef ARGMAX_EN
      chk("class_vld", class_vld, et);
      if (et && class_vld) begin
        chk("class_idx", class_idx, exp_cls);
        got_cls = class_idx;
      end
`else
      chk("class_vld", class_vld, 0);
      chk("class_idx", class_idx, 0);
`endif
      if (et) pending = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer img[] with the show-ahead protocol; mode 0 = rd always, 1 = toggle, 2 = random.
  task automatic feed(input int mode, output int pulses);
    int ptr = 0;
    logic got;
    pulses = 0;
    for (int i = 0; i < 400 && ptr < N_WORDS; i++) begin
      case (mode)
        0:       rd = 1'b1;
        1:       rd = (i % 2 == 0);
        default: rd = ($urandom_range(0, 2) != 0);
      endcase
      for (int c = 0; c < N_CH; c++) din[c] = DW'(img[ptr][c]);
      @(negedge clk); got = addr_rd_inc;
      step();
      if (got) begin ptr++; pulses++; end
    end
    rd = 1'b0;
  endtask

  task automatic run_image(input int mode, input int rd_in_mac);
    int pulses, seen;
    feed(mode, pulses);
    if (rd_in_mac != 0) begin
      rd = 1'b1;
      repeat (60) step();
      rd = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      @(negedge clk); if (tx_done) seen = 1;
      step();
    end
    chk("inc_pulses", pulses, N_WORDS);
    chk("tx_done_seen", seen, 1);
    chk("score_count", got_cnt, N_OUT);
    repeat (3) step();
  endtask

  task automatic set_rand(input int fr, input int wr, input int br);
    for (int n = 0; n < N_OUT; n++) begin
      bm[n] = rnd(br);
      for (int w = 0; w < N_WORDS; w++)
        for (int c = 0; c < N_CH; c++) wm[n][w][c] = rnd(wr);
    end
    for (int w = 0; w < N_WORDS; w++)
      for (int c = 0; c < N_CH; c++) img[w][c] = rnd(fr);
    rom_flush();
  endtask

  initial begin
    int seen;
    // Reset and idle
    rst = 1'b1; rd = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_score_vld", score_vld, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_score", score, 0);
    chk("rst_inc", addr_rd_inc, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_inc", addr_rd_inc, 0);
      step();
    end

    // All-ones, stalled (toggling) load: each score = 64
    for (int n = 0; n < N_OUT; n++) begin
      bm[n] = 0;
      for (int w = 0; w < N_WORDS; w++)
        for (int c = 0; c < N_CH; c++) wm[n][w][c] = 2**SHIFT;
    end
    for (int w = 0; w < N_WORDS; w++)
      for (int c = 0; c < N_CH; c++) img[w][c] = 1;
    rom_flush();
    run_image(1, 0);
    chk("model_ones", exp_sc[0], 64);
    chk("ones_s0", got_sc[0], 64);
    chk("ones_s9", got_sc[9], 64);

    // Saturation both ways (rd held high during compute on the second image)
    for (int n = 0; n < N_OUT; n++)
      for (int w = 0; w < N_WORDS; w++)
        for (int c = 0; c < N_CH; c++) wm[n][w][c] = (w == 0) ? 131071 : 0;
    for (int w = 0; w < N_WORDS; w++)
      for (int c = 0; c < N_CH; c++) img[w][c] = 131071;
    rom_flush();
    run_image(0, 0);
    chk("sat_pos", got_sc[0], 18'h1FFFF);
    for (int n = 0; n < N_OUT; n++)
      for (int c = 0; c < N_CH; c++) wm[n][0][c] = -131071;
    rom_flush();
    run_image(0, 1);
    chk("sat_neg", got_sc[5], 18'h20000);

    // Bias-only scores, neurons 3 and 7 tie for the max
    for (int n = 0; n < N_OUT; n++) begin
      bm[n] = (n == 3 || n == 7) ? 1000 : n*10 - 50;
      for (int w = 0; w < N_WORDS; w++)
        for (int c = 0; c < N_CH; c++) wm[n][w][c] = 0;
    end
    for (int w = 0; w < N_WORDS; w++)
      for (int c = 0; c < N_CH; c++) img[w][c] = rnd(131071);
    rom_flush();
    run_image(2, 0);
    chk("model_bias3", exp_sc[3], 1000);
    chk("bias_s3", got_sc[3], 1000);
    chk("bias_s0", got_sc[0], 18'h3FFCE);
`ifdef ARGMAX_EN
    chk("argmax_tie", got_cls, 3);
`endif

    // Random images at several magnitudes
    set_rand(511, 511, 2000);        run_image(2, 0);
    set_rand(4095, 4095, 60000);     run_image(2, 0);
    set_rand(131071, 131071, 131071); run_image(2, 1);

    // Reset in the middle of the neuron sweep, then a fresh image
    set_rand(2047, 2047, 5000);
    begin
      int pulses;
      feed(0, pulses);
      chk("mid_pulses", pulses, N_WORDS);
    end
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk); if (score_vld && score_idx == 4) seen = 1;
      step();
    end
    chk("reach_n4", seen, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_vld", score_vld, 0);
    chk("midrst_tx", tx_done, 0);
    step();
    repeat (250) step();
    set_rand(2047, 2047, 5000);
    run_image(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
